// File: rtl/sobel_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl_pkg
// Brief    : Shared widths, edge constants, FSM encoding and gradient helper.
// Revision : 1.0
// ============================================================================
package sobel_frame_ctrl_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 12;

  localparam logic [PIX_W-1:0]  EDGE_OFF    = 8'h00;
  localparam logic [PIX_W-1:0]  EDGE_ON     = 8'hFF;
  localparam logic [GRAD_W-1:0] EDGE_THRESH = 12'd127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // (a0 + 2*a1 + a2) - (b0 + 2*b1 + b2); each side is at most 1020, so 12 bits signed never wraps.
  function automatic logic signed [GRAD_W-1:0] grad3(
    input logic [PIX_W-1:0] a0, input logic [PIX_W-1:0] a1, input logic [PIX_W-1:0] a2,
    input logic [PIX_W-1:0] b0, input logic [PIX_W-1:0] b1, input logic [PIX_W-1:0] b2
  );
    logic [GRAD_W-1:0] pos_sum;
    logic [GRAD_W-1:0] neg_sum;
    pos_sum = {{(GRAD_W-PIX_W){1'b0}}, a0} + {{(GRAD_W-PIX_W-1){1'b0}}, a1, 1'b0}
            + {{(GRAD_W-PIX_W){1'b0}}, a2};
    neg_sum = {{(GRAD_W-PIX_W){1'b0}}, b0} + {{(GRAD_W-PIX_W-1){1'b0}}, b1, 1'b0}
            + {{(GRAD_W-PIX_W){1'b0}}, b2};
    return signed'(pos_sum - neg_sum);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_linebuf.sv
`default_nettype none
// ============================================================================
// Module   : sobel_linebuf
// Brief    : Two IMG_W x 8 line memories, combinational read-before-write at addr.
// Revision : 1.0
// ============================================================================
module sobel_linebuf
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int CW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [CW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] rd0,
  output logic [PIX_W-1:0] rd1
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [PIX_W-1:0] line0_mem [IMG_W];
  logic [PIX_W-1:0] line1_mem [IMG_W];
  logic [AW-1:0]    idx;

  assign idx = addr[AW-1:0];

  generate
    if (CW > AW) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[CW-1:AW];
    end
  endgenerate

  assign rd0 = line0_mem[idx];
  assign rd1 = line1_mem[idx];

  // Contents are never reset; the controller only consumes them from row 2 onward.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line1_mem[idx] <= line0_mem[idx];
      line0_mem[idx] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_threshold.sv
`default_nettype none
// ============================================================================
// Module   : sobel_threshold
// Brief    : |Dx|+|Dy| magnitude compare; 0x00 at or below 127, else 0xFF.
// Revision : 1.0
// ============================================================================
module sobel_threshold
  import sobel_frame_ctrl_pkg::*;
(
  input  logic signed [GRAD_W-1:0] dx,
  input  logic signed [GRAD_W-1:0] dy,
  output logic [PIX_W-1:0]         edge_pix
);

  logic [GRAD_W-1:0] abs_dx;
  logic [GRAD_W-1:0] abs_dy;
  logic [GRAD_W-1:0] mag;

  always_comb begin
    abs_dx   = dx[GRAD_W-1] ? unsigned'(-dx) : unsigned'(dx);
    abs_dy   = dy[GRAD_W-1] ? unsigned'(-dy) : unsigned'(dy);
    mag      = abs_dx + abs_dy;
    edge_pix = (mag > EDGE_THRESH) ? EDGE_ON : EDGE_OFF;
  end

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Brief    : Raster Sobel edge controller: line buffers, 3x3 window, 2-stage result.
// Revision : 1.0
// ============================================================================
module sobel_frame_ctrl
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int CW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic [7:0]       pix_out,
  output logic             pix_out_valid,
  output logic [CW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             busy,
  output logic             done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE_MIN = CW'(2);

  state_e state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    drain_q, drain_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] win_d [3][2];
  logic [PIX_W-1:0] col_new [3];

  logic                     v1_q, v1_d;
  logic signed [GRAD_W-1:0] dx_q, dx_d;
  logic signed [GRAD_W-1:0] dy_q, dy_d;
  logic [CW-1:0]            row1_q, row1_d;
  logic [CW-1:0]            col1_q, col1_d;

  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_out_valid_q, pix_out_valid_d;
  logic [CW-1:0]    out_row_q, out_row_d;
  logic [CW-1:0]    out_col_q, out_col_d;

  logic                     accept;
  logic [PIX_W-1:0]         lb_rd0;
  logic [PIX_W-1:0]         lb_rd1;
  logic signed [GRAD_W-1:0] dx_w;
  logic signed [GRAD_W-1:0] dy_w;
  logic [PIX_W-1:0]         edge_w;

  assign pix_in_ready = (state_q == ST_RUN);
  assign accept       = pix_in_valid && pix_in_ready;

  sobel_linebuf #(
    .IMG_W (IMG_W),
    .CW    (CW)
  ) u_linebuf (
    .clk   (clk),
    .wr_en (accept),
    .addr  (col_q),
    .din   (pix_in),
    .rd0   (lb_rd0),
    .rd1   (lb_rd1)
  );

  // Right window column is the incoming one, used combinationally; only the left two are stored.
  assign col_new[0] = lb_rd1;
  assign col_new[1] = lb_rd0;
  assign col_new[2] = pix_in;

  assign dx_w = grad3(col_new[0], col_new[1], col_new[2], win_q[0][0], win_q[1][0], win_q[2][0]);
  assign dy_w = grad3(win_q[2][0], win_q[2][1], col_new[2], win_q[0][0], win_q[0][1], col_new[0]);

  sobel_threshold u_threshold (
    .dx       (dx_q),
    .dy       (dy_q),
    .edge_pix (edge_w)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    drain_d = drain_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              drain_d = '0;
              state_d = ST_DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Final result appears on the 2nd drain cycle; done follows it, IDLE one cycle later.
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd1) begin
          done_d = 1'b1;
        end
        if (drain_q == 2'd2) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][0];
      win_d[r][1] = win_q[r][1];
    end
    v1_d   = 1'b0;
    dx_d   = dx_q;
    dy_d   = dy_q;
    row1_d = row1_q;
    col1_d = col1_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col_new[r];
      end
      v1_d   = (row_q >= EDGE_MIN) && (col_q >= EDGE_MIN);
      dx_d   = dx_w;
      dy_d   = dy_w;
      row1_d = row_q - 1'b1;
      col1_d = col_q - 1'b1;
    end

    pix_out_valid_d = v1_q;
    pix_out_d       = pix_out_q;
    out_row_d       = out_row_q;
    out_col_d       = out_col_q;
    if (v1_q) begin
      pix_out_d = edge_w;
      out_row_d = row1_q;
      out_col_d = col1_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      win_q[r][0] <= win_d[r][0];
      win_q[r][1] <= win_d[r][1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      drain_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      v1_q            <= 1'b0;
      dx_q            <= '0;
      dy_q            <= '0;
      row1_q          <= '0;
      col1_q          <= '0;
      pix_out_q       <= EDGE_OFF;
      pix_out_valid_q <= 1'b0;
      out_row_q       <= '0;
      out_col_q       <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      drain_q         <= drain_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      v1_q            <= v1_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      row1_q          <= row1_d;
      col1_q          <= col1_d;
      pix_out_q       <= pix_out_d;
      pix_out_valid_q <= pix_out_valid_d;
      out_row_q       <= out_row_d;
      out_col_q       <= out_col_d;
    end
  end

  assign pix_out       = pix_out_q;
  assign pix_out_valid = pix_out_valid_q;
  assign out_row       = out_row_q;
  assign out_col       = out_col_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sobel_frame_ctrl
// Brief    : Randomized self-checking bench with an array-based Sobel reference.
// Revision : 1.0
// ============================================================================
module tb_sobel_frame_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = 10;
  localparam int N_RES = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    pix_in;
  logic          pix_in_valid;
  logic          pix_in_ready;
  logic [7:0]    pix_out;
  logic          pix_out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          done;

  sobel_frame_ctrl #(
    .IMG_W (W),
    .IMG_H (H),
    .CW    (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_out       (pix_out),
    .pix_out_valid (pix_out_valid),
    .out_row       (out_row),
    .out_col       (out_col),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the whole frame is known up front, results are computed straight from it.
  int img [H][W];

  typedef struct {
    int row;
    int col;
    int pix;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  exp_t e_new;
  int   cyc = 0;
  int   acc_n = 0;
  int   n_res = 0;
  int   n_done = 0;
  int   last_valid_cyc = -100;
  int   mr, mc;

  function automatic int ref_edge(input int r, input int c);
    int dx, dy;
    dx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    dy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx + dy > 127) ? 255 : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pix_out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_result", 32'd1, 32'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check_val("out_row", 32'(out_row), 32'(e_mon.row));
        check_val("out_col", 32'(out_col), 32'(e_mon.col));
        check_val("pix_out", 32'(pix_out), 32'(e_mon.pix));
        check_val("latency_cycle", 32'(cyc), 32'(e_mon.cyc));
      end
      n_res++;
      last_valid_cyc = cyc;
    end
    if (done) begin
      n_done++;
      check_val("done_after_last", 32'(cyc), 32'(last_valid_cyc + 1));
    end
    if (rst) begin
      exp_q.delete();
      acc_n = 0;
    end else if (pix_in_valid && pix_in_ready) begin
      mr = acc_n / W;
      mc = acc_n % W;
      if (mr >= 2 && mc >= 2) begin
        e_new.row = mr - 1;
        e_new.col = mc - 1;
        e_new.pix = ref_edge(mr - 1, mc - 1);
        e_new.cyc = cyc + 2;
        exp_q.push_back(e_new);
      end
      acc_n = (acc_n + 1) % (W * H);
    end
  end

  task automatic fill_img(input int mode);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (mode)
          0: img[r][c] = 100;
          1: img[r][c] = (c < W/2) ? 0 : 200;
          2: img[r][c] = (c < W/2) ? 0 : 31;
          3: img[r][c] = (c < W/2) ? 0 : 32;
          default: img[r][c] = int'($urandom_range(255));
        endcase
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input int p, input int gap_pct, input bit poke_start);
    int guard;
    while (int'($urandom_range(99)) < gap_pct) begin
      pix_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_in       = 8'(p);
    pix_in_valid = 1'b1;
    start        = poke_start;
    guard        = 0;
    @(negedge clk);
    while (!pix_in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!pix_in_ready) check_val("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    pix_in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic run_frame(input string name, input int mode, input int gap_pct, input int poke_idx);
    int guard;
    fill_img(mode);
    n_res  = 0;
    n_done = 0;
    pulse_start();
    for (int i = 0; i < W * H; i++) begin
      send_pix(img[i / W][i % W], gap_pct, i == poke_idx);
    end
    guard = 0;
    while (n_done == 0 && guard < 40) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val({name, "_done_count"}, 32'(n_done), 32'd1);
    check_val({name, "_result_count"}, 32'(n_res), 32'(N_RES));
    check_val({name, "_busy_idle"}, 32'(busy), 32'd0);
    check_val({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pix_in       = 8'd0;
    pix_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(pix_in_ready), 32'd0);
    check_val("rst_pix_out", 32'(pix_out), 32'd0);
    check_val("rst_valid", 32'(pix_out_valid), 32'd0);
    check_val("rst_row", 32'(out_row), 32'd0);
    check_val("rst_col", 32'(out_col), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame("uniform", 0, 0, -1);
    run_frame("step200", 1, 0, -1);
    run_frame("step31", 2, 0, -1);
    run_frame("step32", 3, 0, -1);
    run_frame("step200_gaps", 1, 50, -1);
    run_frame("random_gaps", 4, 30, -1);
    run_frame("random", 4, 0, -1);

    // Abort a frame after 20 accepts; in-flight results must vanish.
    fill_img(0);
    n_res  = 0;
    n_done = 0;
    pulse_start();
    for (int i = 0; i < 20; i++) send_pix(img[i / W][i % W], 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("midrst_ready", 32'(pix_in_ready), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_valid", 32'(pix_out_valid), 32'd0);
    n_res = 0;
    repeat (6) @(posedge clk);
    #1;
    check_val("midrst_no_done", 32'(n_done), 32'd0);
    check_val("midrst_no_results", 32'(n_res), 32'd0);
    run_frame("after_reset", 0, 0, -1);

    run_frame("start_in_run", 1, 0, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
